// File: rtl/axi_master_pkg.sv
// Shared types and AXI constants for the CPU-to-AXI master bridge.
// Bus widths and response codes mirror the interconnect's AXI definitions.
package axi_master_pkg;

    localparam int unsigned AXI_ID_BITS   = 4;
    localparam int unsigned AXI_ADDR_BITS = 32;
    localparam int unsigned AXI_DATA_BITS = 32;
    localparam int unsigned AXI_STRB_BITS = AXI_DATA_BITS / 8;
    localparam int unsigned AXI_LEN_BITS  = 4;
    localparam int unsigned AXI_SIZE_BITS = 3;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [AXI_SIZE_BITS-1:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0]               AXI_BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAr   = 3'd1,
        StR    = 3'd2,
        StAw   = 3'd3,
        StW    = 3'd4,
        StB    = 3'd5
    } state_e;

endpackage

// File: rtl/axi_master_bridge.sv
// Turns one CPU memory request into a single AXI4 INCR burst (1..16 words).
// One transaction in flight; writes always present AW before any W beat.
module axi_master_bridge
    import axi_master_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    // CPU request side
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [31:0]               req_addr,
    input  logic [3:0]                req_len,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strb,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic [31:0]               rd_data,
    output logic                      rd_valid,
    output logic                      rd_last,
    input  logic                      rd_ready,
    output logic                      done,
    output logic                      err,
    // AW channel
    output logic [AXI_ID_BITS-1:0]    AWID_M,
    output logic [AXI_ADDR_BITS-1:0]  AWADDR_M,
    output logic [AXI_LEN_BITS-1:0]   AWLEN_M,
    output logic [AXI_SIZE_BITS-1:0]  AWSIZE_M,
    output logic [1:0]                AWBURST_M,
    output logic                      AWVALID_M,
    input  logic                      AWREADY_M,
    // W channel
    output logic [AXI_DATA_BITS-1:0]  WDATA_M,
    output logic [AXI_STRB_BITS-1:0]  WSTRB_M,
    output logic                      WLAST_M,
    output logic                      WVALID_M,
    input  logic                      WREADY_M,
    // B channel
    input  logic [AXI_ID_BITS-1:0]    BID_M,
    input  logic [1:0]                BRESP_M,
    input  logic                      BVALID_M,
    output logic                      BREADY_M,
    // AR channel
    output logic [AXI_ID_BITS-1:0]    ARID_M,
    output logic [AXI_ADDR_BITS-1:0]  ARADDR_M,
    output logic [AXI_LEN_BITS-1:0]   ARLEN_M,
    output logic [AXI_SIZE_BITS-1:0]  ARSIZE_M,
    output logic [1:0]                ARBURST_M,
    output logic                      ARVALID_M,
    input  logic                      ARREADY_M,
    // R channel
    input  logic [AXI_ID_BITS-1:0]    RID_M,
    input  logic [AXI_DATA_BITS-1:0]  RDATA_M,
    input  logic [1:0]                RRESP_M,
    input  logic                      RLAST_M,
    input  logic                      RVALID_M,
    output logic                      RREADY_M
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic        r_hs;
    logic        w_hs;
    logic        w_last;

    // Response IDs need no check with a single outstanding burst.
    logic        unused_ins;
    assign unused_ins = ^{RID_M, BID_M, req_addr[1:0]};

    assign r_hs   = (state_q == StR) && RVALID_M && rd_ready;
    assign w_hs   = (state_q == StW) && wr_valid && WREADY_M;
    assign w_last = (cnt_q == len_q);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = {req_addr[31:2], 2'b00};
                    len_d   = req_len;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = req_write ? StAw : StAr;
                end
            end
            StAr: begin
                if (ARREADY_M) state_d = StR;
            end
            StR: begin
                if (r_hs) begin
                    cnt_d = cnt_q + 4'd1;
                    if (RRESP_M != AXI_RESP_OKAY) err_d = 1'b1;
                    if (RLAST_M) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StAw: begin
                if (AWREADY_M) state_d = StW;
            end
            StW: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 4'd1;
                    if (w_last) state_d = StB;
                end
            end
            StB: begin
                if (BVALID_M) begin
                    if (BRESP_M != AXI_RESP_OKAY) err_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign done      = done_q;
    assign err       = err_q;

    assign ARID_M    = MASTER_ID;
    assign ARADDR_M  = addr_q;
    assign ARLEN_M   = len_q;
    assign ARSIZE_M  = AXI_SIZE_WORD;
    assign ARBURST_M = AXI_BURST_INCR;
    assign ARVALID_M = (state_q == StAr);

    assign RREADY_M  = (state_q == StR) && rd_ready;
    assign rd_valid  = (state_q == StR) && RVALID_M;
    assign rd_last   = (state_q == StR) && RLAST_M;
    assign rd_data   = RDATA_M;

    assign AWID_M    = MASTER_ID;
    assign AWADDR_M  = addr_q;
    assign AWLEN_M   = len_q;
    assign AWSIZE_M  = AXI_SIZE_WORD;
    assign AWBURST_M = AXI_BURST_INCR;
    assign AWVALID_M = (state_q == StAw);

    assign WVALID_M  = (state_q == StW) && wr_valid;
    assign wr_ready  = (state_q == StW) && WREADY_M;
    assign WDATA_M   = wr_data;
    assign WSTRB_M   = wr_strb;
    assign WLAST_M   = (state_q == StW) && w_last;

    assign BREADY_M  = (state_q == StB);

endmodule

// File: tb/tb_axi_master_bridge.sv
// Bench for axi_master_bridge: randomized CPU requests, a reactive AXI slave with its own
// memory, and a word-level reference memory updated from the requests themselves.
`timescale 1ns/1ps
module tb_axi_master_bridge;
    import axi_master_pkg::*;

    localparam logic [3:0] TB_ID = 4'd5;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic req_valid = 1'b0, req_write = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
    logic [31:0] req_addr = '0, wr_data = '0;
    logic [3:0] req_len = '0, wr_strb = '0;
    logic req_ready, wr_ready, rd_valid, rd_last, done, err;
    logic [31:0] rd_data;
    logic [3:0] AWID_M, AWLEN_M, ARID_M, ARLEN_M, WSTRB_M, BID_M, RID_M;
    logic [31:0] AWADDR_M, ARADDR_M, WDATA_M, RDATA_M;
    logic [2:0] AWSIZE_M, ARSIZE_M;
    logic [1:0] AWBURST_M, ARBURST_M, BRESP_M, RRESP_M;
    logic AWVALID_M, AWREADY_M, WLAST_M, WVALID_M, WREADY_M, BVALID_M, BREADY_M;
    logic ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M;

    axi_master_bridge #(.MASTER_ID(TB_ID)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .err(err),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(negedge ACLK) cyc <= cyc + 1;

    // Memories: slave memory filled from bus traffic, reference filled from requests.
    logic [31:0] slv_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] init_word(input int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction
    function automatic logic [31:0] slv_rd(input int unsigned w);
        return slv_mem.exists(w) ? slv_mem[w] : init_word(w);
    endfunction
    function automatic logic [31:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Slave configuration and logs
    int unsigned ar_delay = 0, aw_delay = 0, b_delay = 0;
    int unsigned r_gap_pct = 0, w_ready_pct = 100;
    bit aw_early = 1'b0;
    logic [1:0] bresp_cfg = AXI_RESP_OKAY, rresp_cfg = AXI_RESP_OKAY;
    int rresp_beat = -1;
    int ar_cnt = 0, aw_cnt = 0, w_hs = 0, bready_low = 0;
    logic [31:0] ar_addr = '0, aw_addr = '0;
    logic [3:0] ar_len = '0, aw_len = '0;
    logic [8:0] ar_attr = '0, aw_attr = '0;
    logic [31:0] w_dat [32];
    logic [3:0] w_stb [32];
    logic w_lst [32];

    // Slave state
    bit r_act, r_hold, w_act, b_act;
    int unsigned r_idx, w_idx, r_word, w_word, ar_wait, aw_wait, b_wait;
    int r_len;

    initial begin
        ARREADY_M = 0; AWREADY_M = 0; WREADY_M = 0; RVALID_M = 0; RDATA_M = '0; RLAST_M = 0;
        RRESP_M = '0; RID_M = '0; BVALID_M = 0; BRESP_M = '0; BID_M = '0;
        r_act = 0; r_hold = 0; w_act = 0; b_act = 0;
        r_idx = 0; w_idx = 0; r_word = 0; w_word = 0; ar_wait = 0; aw_wait = 0; b_wait = 0;
        r_len = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                ARREADY_M = 0; AWREADY_M = 0; WREADY_M = 0; RVALID_M = 0; RLAST_M = 0;
                BVALID_M = 0; RRESP_M = '0; BRESP_M = '0;
                r_act = 0; r_hold = 0; w_act = 0; b_act = 0; ar_wait = 0; aw_wait = 0;
            end else begin
                ARREADY_M = ARVALID_M && (ar_wait >= ar_delay);
                AWREADY_M = aw_early || (AWVALID_M && (aw_wait >= aw_delay));
                WREADY_M  = ($urandom_range(0, 99) < w_ready_pct);
                if (r_act) begin
                    RVALID_M = r_hold || ($urandom_range(0, 99) >= r_gap_pct);
                    RDATA_M  = slv_rd(r_word + r_idx);
                    RLAST_M  = (int'(r_idx) == r_len);
                    RRESP_M  = (int'(r_idx) == rresp_beat) ? rresp_cfg : AXI_RESP_OKAY;
                    RID_M    = TB_ID;
                end else begin
                    RVALID_M = 0; RLAST_M = 0; RRESP_M = AXI_RESP_OKAY;
                end
                BVALID_M = b_act && (b_wait >= b_delay);
                BRESP_M  = bresp_cfg;
                BID_M    = TB_ID;
                #1;
                if (b_act && !BREADY_M) bready_low++;
                if (ARVALID_M && ARREADY_M) begin
                    ar_cnt++; ar_addr = ARADDR_M; ar_len = ARLEN_M;
                    ar_attr = {ARID_M, ARSIZE_M, ARBURST_M};
                    r_act = 1; r_hold = 0; r_idx = 0; r_word = int'(ARADDR_M[31:2]);
                    r_len = int'(ARLEN_M); ar_wait = 0;
                end else if (ARVALID_M) ar_wait++;
                else ar_wait = 0;
                if (AWVALID_M && AWREADY_M) begin
                    aw_cnt++; aw_addr = AWADDR_M; aw_len = AWLEN_M;
                    aw_attr = {AWID_M, AWSIZE_M, AWBURST_M};
                    w_act = 1; w_idx = 0; w_word = int'(AWADDR_M[31:2]); aw_wait = 0;
                end else if (AWVALID_M) aw_wait++;
                else aw_wait = 0;
                if (RVALID_M && RREADY_M) begin
                    r_idx++; r_hold = 0;
                    if (RLAST_M) r_act = 0;
                end else r_hold = RVALID_M;
                if (b_act) begin
                    if (BVALID_M && BREADY_M) b_act = 0;
                    else b_wait++;
                end
                if (WVALID_M && WREADY_M && w_act) begin
                    slv_mem[w_word + w_idx] = merge(slv_rd(w_word + w_idx), WDATA_M, WSTRB_M);
                    if (w_hs < 32) begin
                        w_dat[w_hs] = WDATA_M; w_stb[w_hs] = WSTRB_M; w_lst[w_hs] = WLAST_M;
                    end
                    w_hs++; w_idx++;
                    if (WLAST_M) begin w_act = 0; b_act = 1; b_wait = 0; end
                end
            end
        end
    end

    // CPU-side driver state and observations
    logic [31:0] tx_data [16];
    logic [3:0] tx_strb [16];
    logic [31:0] rx_data [16];
    logic rx_last [16];
    int rx_cnt, wbeats, done_cnt, mirror_err;
    int unsigned acc_cyc, last_hs_cyc, done_cyc;
    bit timeout, axvalid_next, err_after_acc, b2b_acc, rd_alt;
    int unsigned cpu_gap = 0;

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                           input bit pre, input bit nxt, input logic [31:0] nxt_addr,
                           input logic [3:0] nxt_len);
        int n, budget;
        bit rphase;
        rx_cnt = 0; wbeats = 0; done_cnt = 0; mirror_err = 0; timeout = 0;
        axvalid_next = 0; err_after_acc = 1; b2b_acc = 0; n = 0; rphase = 0;
        last_hs_cyc = 0; done_cyc = 0;
        if (!pre) begin
            budget = 0;
            forever begin
                @(negedge ACLK);
                req_valid = 1; req_write = wr; req_addr = addr; req_len = len;
                #1;
                if (req_ready) break;
                budget++;
                if (budget > 200) begin timeout = 1; req_valid = 0; return; end
            end
        end
        acc_cyc = cyc;
        budget = 0;
        forever begin
            @(negedge ACLK);
            if (nxt) begin
                req_valid = 1; req_write = 0; req_addr = nxt_addr; req_len = nxt_len;
            end else req_valid = 0;
            wr_valid = wr && (n <= int'(len)) && ($urandom_range(0, 99) >= cpu_gap);
            wr_data  = (n < 16) ? tx_data[n] : '0;
            wr_strb  = (n < 16) ? tx_strb[n] : '0;
            rd_ready = rd_alt ? cyc[0] : ($urandom_range(0, 99) >= cpu_gap);
            #1;
            if (cyc == acc_cyc + 1) begin
                axvalid_next  = wr ? AWVALID_M : ARVALID_M;
                err_after_acc = err;
            end
            if (rphase && (RREADY_M !== rd_ready)) mirror_err++;
            if (ARVALID_M && ARREADY_M) rphase = 1;
            if (wr_valid && wr_ready) begin n++; wbeats++; last_hs_cyc = cyc; end
            if (rd_valid && rd_ready) begin
                if (rx_cnt < 16) begin rx_data[rx_cnt] = rd_data; rx_last[rx_cnt] = rd_last; end
                rx_cnt++; last_hs_cyc = cyc;
                if (rd_last) rphase = 0;
            end
            if (done) begin
                done_cnt++; done_cyc = cyc;
                break;
            end
            budget++;
            if (budget > 1500) begin
                timeout = 1; req_valid = 0; wr_valid = 0; rd_ready = 0;
                return;
            end
        end
        if (nxt) begin
            b2b_acc = req_valid && req_ready;
            wr_valid = 0; rd_ready = 0;
            return;
        end
        @(negedge ACLK);
        req_valid = 0; wr_valid = 0; rd_ready = 0;
        #1;
        if (done) done_cnt++;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        checks++;
        if ({ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M} !== 5'b0) begin
            errors++; $display("FAIL reset_valid_ready: got %b expected 00000",
                {ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M});
        end
        checks++;
        if ({done, err, rd_valid, wr_ready} !== 4'b0) begin
            errors++; $display("FAIL reset_status: got %b expected 0000",
                {done, err, rd_valid, wr_ready});
        end
        checks++;
        if ({ARADDR_M, ARLEN_M} !== 36'h0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", {ARADDR_M, ARLEN_M});
        end
        repeat (3) @(negedge ACLK);
        #2 ARESETn = 1'b1;
    endtask

    task automatic test_single_read();
        ar_delay = 2; r_gap_pct = 0; cpu_gap = 0; rd_alt = 0;
        slv_mem[32'h104 >> 2] = 32'hDEAD_BEEF;
        ref_mem[32'h104 >> 2] = 32'hDEAD_BEEF;
        run_txn(1'b0, 32'h0000_0104, 4'd0, 1'b0, 1'b0, '0, '0);
        checks++;
        if ({timeout, ar_addr, ar_len} !== {1'b0, 32'h104, 4'd0}) begin
            errors++; $display("FAIL single_read_ar: got to=%b addr=%h len=%0d expected 0/104/0",
                timeout, ar_addr, ar_len);
        end
        checks++;
        if (ar_attr !== {TB_ID, 3'b010, 2'b01}) begin
            errors++; $display("FAIL single_read_attr: got %h expected %h", ar_attr,
                {TB_ID, 3'b010, 2'b01});
        end
        checks++;
        if ({rx_cnt, rx_data[0], rx_last[0]} !== {32'd1, 32'hDEAD_BEEF, 1'b1}) begin
            errors++; $display("FAIL single_read_data: got n=%0d %h last=%b expected 1 deadbeef 1",
                rx_cnt, rx_data[0], rx_last[0]);
        end
        checks++;
        if (done_cyc !== last_hs_cyc + 1) begin
            errors++; $display("FAIL single_read_done_timing: got +%0d expected +1",
                done_cyc - last_hs_cyc);
        end
        checks++;
        if ({done_cnt, err, axvalid_next} !== {32'd1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL single_read_status: got done=%0d err=%b arv=%b expected 1 0 1",
                done_cnt, err, axvalid_next);
        end
        ar_delay = 0;
    endtask

    task automatic test_write_gaps();
        for (int i = 0; i < 4; i++) begin tx_data[i] = 32'(i + 1); tx_strb[i] = 4'hF; end
        w_hs = 0; bready_low = 0; cpu_gap = 50; w_ready_pct = 70; b_delay = 3;
        run_txn(1'b1, 32'h0000_0200, 4'd3, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) ref_mem[(32'h200 >> 2) + i] = tx_data[i];
        checks++;
        if ({timeout, aw_addr, aw_len, w_hs} !== {1'b0, 32'h200, 4'd3, 32'd4}) begin
            errors++; $display("FAIL write_gaps_beats: got to=%b addr=%h len=%0d hs=%0d expected 0/200/3/4",
                timeout, aw_addr, aw_len, w_hs);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({w_dat[i], w_stb[i], w_lst[i]} !== {32'(i + 1), 4'hF, (i == 3)}) begin
                errors++; $display("FAIL write_gaps_beat%0d: got %h/%h/%b expected %h/f/%b",
                    i, w_dat[i], w_stb[i], w_lst[i], i + 1, i == 3);
            end
        end
        checks++;
        if ({bready_low, done_cnt, err} !== {32'd0, 32'd1, 1'b0}) begin
            errors++; $display("FAIL write_gaps_b: got bready_low=%0d done=%0d err=%b expected 0 1 0",
                bready_low, done_cnt, err);
        end
        b_delay = 0; w_ready_pct = 100; cpu_gap = 0;
    endtask

    task automatic test_read_stalls();
        logic [15:0] lmask;
        rd_alt = 1; r_gap_pct = 20;
        run_txn(1'b0, 32'h0000_01F0, 4'd7, 1'b0, 1'b0, '0, '0);
        rd_alt = 0; r_gap_pct = 0;
        checks++;
        if ({timeout, rx_cnt, mirror_err, done_cnt} !== {1'b0, 32'd8, 32'd0, 32'd1}) begin
            errors++; $display("FAIL read_stalls_flow: got to=%b n=%0d mirror=%0d done=%0d expected 0 8 0 1",
                timeout, rx_cnt, mirror_err, done_cnt);
        end
        lmask = '0;
        for (int i = 0; i < 8; i++) begin
            lmask[i] = rx_last[i];
            checks++;
            if (rx_data[i] !== ref_rd((32'h1F0 >> 2) + i)) begin
                errors++; $display("FAIL read_stalls_beat%0d: got %h expected %h", i, rx_data[i],
                    ref_rd((32'h1F0 >> 2) + i));
            end
        end
        checks++;
        if (lmask !== 16'h0080) begin
            errors++; $display("FAIL read_stalls_last: got %h expected 0080", lmask);
        end
    endtask

    task automatic test_error();
        tx_data[0] = 32'hCAFE_0001; tx_strb[0] = 4'hF;
        bresp_cfg = AXI_RESP_SLVERR;
        run_txn(1'b1, 32'h0000_0500, 4'd0, 1'b0, 1'b0, '0, '0);
        bresp_cfg = AXI_RESP_OKAY;
        ref_mem[32'h500 >> 2] = 32'hCAFE_0001;
        checks++;
        if ({timeout, err} !== 2'b01) begin
            errors++; $display("FAIL err_bresp: got to=%b err=%b expected 0 1", timeout, err);
        end
        rresp_cfg = AXI_RESP_SLVERR; rresp_beat = 1;
        run_txn(1'b0, 32'h0000_0500, 4'd2, 1'b0, 1'b0, '0, '0);
        rresp_cfg = AXI_RESP_OKAY; rresp_beat = -1;
        checks++;
        if ({timeout, err_after_acc, err, rx_cnt} !== {1'b0, 1'b0, 1'b1, 32'd3}) begin
            errors++; $display("FAIL err_rresp: got to=%b clr=%b err=%b n=%0d expected 0 0 1 3",
                timeout, err_after_acc, err, rx_cnt);
        end
        run_txn(1'b0, 32'h0000_0500, 4'd0, 1'b0, 1'b0, '0, '0);
        checks++;
        if ({err_after_acc, err, rx_data[0]} !== {1'b0, 1'b0, 32'hCAFE_0001}) begin
            errors++; $display("FAIL err_clear: got clr=%b err=%b d=%h expected 0 0 cafe0001",
                err_after_acc, err, rx_data[0]);
        end
    endtask

    task automatic test_back_to_back();
        r_gap_pct = 30;
        run_txn(1'b0, 32'h0000_0600, 4'd3, 1'b0, 1'b1, 32'h0000_0640, 4'd1);
        checks++;
        if ({timeout, b2b_acc, rx_cnt} !== {1'b0, 1'b1, 32'd4}) begin
            errors++; $display("FAIL b2b_accept: got to=%b acc=%b n=%0d expected 0 1 4",
                timeout, b2b_acc, rx_cnt);
        end
        run_txn(1'b0, 32'h0000_0640, 4'd1, 1'b1, 1'b0, '0, '0);
        checks++;
        if ({timeout, axvalid_next, ar_addr, rx_cnt, rx_data[1]} !==
            {1'b0, 1'b1, 32'h640, 32'd2, ref_rd((32'h640 >> 2) + 1)}) begin
            errors++; $display("FAIL b2b_second: got to=%b arv=%b addr=%h n=%0d d1=%h expected 0 1 640 2 %h",
                timeout, axvalid_next, ar_addr, rx_cnt, rx_data[1], ref_rd((32'h640 >> 2) + 1));
        end
        r_gap_pct = 0;
    endtask

    task automatic test_reset_during_w();
        int hs, budget;
        for (int i = 0; i < 4; i++) begin tx_data[i] = 32'hB000_0000 + i; tx_strb[i] = 4'hF; end
        hs = 0; budget = 0;
        @(negedge ACLK);
        req_valid = 1; req_write = 1; req_addr = 32'h300; req_len = 4'd3;
        while (hs < 2 && budget < 100) begin
            @(negedge ACLK);
            req_valid = 0; wr_valid = 1; wr_data = tx_data[hs]; wr_strb = 4'hF;
            #1;
            if (wr_valid && wr_ready) hs++;
            budget++;
        end
        @(posedge ACLK);
        #2 ARESETn = 1'b0;
        #1;
        checks++;
        if ({hs, ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, wr_ready, rd_valid} !==
            {32'd2, 7'b0}) begin
            errors++; $display("FAIL reset_mid_w_outputs: got hs=%0d bits=%b expected 2 0000000", hs,
                {ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, wr_ready, rd_valid});
        end
        wr_valid = 0;
        repeat (3) @(negedge ACLK);
        #2 ARESETn = 1'b1;
        #1;
        checks++;
        if ({req_ready, done, err} !== 3'b100) begin
            errors++; $display("FAIL reset_mid_w_release: got %b expected 100", {req_ready, done, err});
        end
        run_txn(1'b0, 32'h0000_0400, 4'd2, 1'b0, 1'b0, '0, '0);
        checks++;
        if ({timeout, rx_cnt, done_cnt, rx_data[2]} !==
            {1'b0, 32'd3, 32'd1, ref_rd((32'h400 >> 2) + 2)}) begin
            errors++; $display("FAIL reset_mid_w_fresh_read: got to=%b n=%0d done=%0d d2=%h expected 0 3 1 %h",
                timeout, rx_cnt, done_cnt, rx_data[2], ref_rd((32'h400 >> 2) + 2));
        end
    endtask

    task automatic test_random();
        bit wr;
        logic [3:0] len;
        int unsigned wbase;
        logic [31:0] addr;
        int bad;
        logic [15:0] lmask;
        for (int t = 0; t < 30; t++) begin
            wr = 1'($urandom_range(0, 1));
            len = (t < 2) ? 4'd15 : 4'($urandom_range(0, 15));
            wbase = 32'h400 + $urandom_range(0, 63 - int'(len));
            addr = {wbase[29:0], 2'($urandom_range(0, 3))};
            ar_delay = $urandom_range(0, 3); aw_delay = $urandom_range(0, 3);
            aw_early = 1'($urandom_range(0, 1)); b_delay = $urandom_range(0, 3);
            w_ready_pct = $urandom_range(40, 100); r_gap_pct = $urandom_range(0, 60);
            cpu_gap = $urandom_range(0, 60);
            for (int i = 0; i < 16; i++) begin
                tx_data[i] = $urandom; tx_strb[i] = 4'($urandom_range(0, 15));
            end
            w_hs = 0; bready_low = 0;
            run_txn(wr, addr, len, 1'b0, 1'b0, '0, '0);
            bad = 0; lmask = '0;
            if (wr) begin
                for (int i = 0; i <= int'(len); i++) begin
                    ref_mem[wbase + i] = merge(ref_rd(wbase + i), tx_data[i], tx_strb[i]);
                    if ({w_dat[i], w_stb[i]} !== {tx_data[i], tx_strb[i]}) bad++;
                    lmask[i] = w_lst[i];
                end
                checks++;
                if ({timeout, aw_addr, aw_len, w_hs, bad, lmask, done_cnt, bready_low} !==
                    {1'b0, wbase[29:0], 2'b00, len, int'(len) + 1, 32'd0, 16'(1) << len, 32'd1,
                     32'd0}) begin
                    errors++; $display("FAIL random_write%0d: got to=%b addr=%h len=%0d hs=%0d bad=%0d last=%h done=%0d expected addr=%h len=%0d",
                        t, timeout, aw_addr, aw_len, w_hs, bad, lmask, done_cnt, {wbase[29:0], 2'b00}, len);
                end
            end else begin
                for (int i = 0; i <= int'(len); i++) begin
                    if (rx_data[i] !== ref_rd(wbase + i)) bad++;
                    lmask[i] = rx_last[i];
                end
                checks++;
                if ({timeout, ar_addr, ar_len, rx_cnt, bad, lmask, done_cnt, mirror_err} !==
                    {1'b0, wbase[29:0], 2'b00, len, int'(len) + 1, 32'd0, 16'(1) << len, 32'd1,
                     32'd0}) begin
                    errors++; $display("FAIL random_read%0d: got to=%b addr=%h len=%0d n=%0d bad=%0d last=%h done=%0d mirror=%0d expected addr=%h len=%0d",
                        t, timeout, ar_addr, ar_len, rx_cnt, bad, lmask, done_cnt, mirror_err,
                        {wbase[29:0], 2'b00}, len);
                end
            end
        end
        aw_early = 0; ar_delay = 0; aw_delay = 0; b_delay = 0; w_ready_pct = 100;
        r_gap_pct = 0; cpu_gap = 0;
    endtask

    initial begin
        rd_alt = 0;
        test_reset();
        test_single_read();
        test_write_gaps();
        test_read_stalls();
        test_error();
        test_back_to_back();
        test_reset_during_w();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
